pipeline_hazard_ctrl: RTL

//  Sequencing controller for the 5-stage MIPS pipeline datapath. Drives the PC and IF/ID

---
 rtl/mips_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS pipeline hazard controller
package mips_pkg;

    // Next-PC source select driven to the PC mux
    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_t;

    // Sequencing states of the hazard controller
    typedef enum logic [1:0] {
        RUN = 2'd0,
        HAZ = 2'd1,
        FRZ = 2'd2
    } haz_state_t;

    // Register $zero is hard-wired and never creates a dependency
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use / branch-operand hazard bubble count
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_ADR_W = 5
) (
    input  logic [REG_ADR_W-1:0] i_id_rs,
    input  logic [REG_ADR_W-1:0] i_id_rt,
    input  logic                 i_id_uses_rt,
    input  logic                 i_id_branch,
    input  logic                 i_ex_reg_write,
    input  logic                 i_ex_mem_read,
    input  logic [REG_ADR_W-1:0] i_ex_write_reg,
    input  logic                 i_mem_mem_read,
    input  logic [REG_ADR_W-1:0] i_mem_write_reg,
    output logic [1:0]           o_n
);

    logic w_ex_hit;
    logic w_mem_hit;

    // A destination matches when it is not $zero and feeds Rs, or Rt when Rt is read
    assign w_ex_hit  = (i_ex_write_reg != REG_ADR_W'(REG_ZERO)) &&
                       ((i_ex_write_reg == i_id_rs) ||
                        (i_id_uses_rt && (i_ex_write_reg == i_id_rt)));
    assign w_mem_hit = (i_mem_write_reg != REG_ADR_W'(REG_ZERO)) &&
                       ((i_mem_write_reg == i_id_rs) ||
                        (i_id_uses_rt && (i_mem_write_reg == i_id_rt)));

    // Largest bubble count demanded by any matching rule; a branch on an EX load needs two
    always_comb begin
        o_n = 2'd0;
        if (i_ex_mem_read && w_ex_hit) begin
            o_n = i_id_branch ? 2'd2 : 2'd1;
        end else if ((i_id_branch && i_ex_reg_write && w_ex_hit) ||
                     (i_id_branch && i_mem_mem_read && w_mem_hit)) begin
            o_n = 2'd1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage MIPS PC/IF-ID sequencing FSM; PIPE_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_ADR_W = 5,
    parameter int MEM_TO    = 64
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int PERF_W    = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_ADR_W-1:0] idRs,
    input  logic [REG_ADR_W-1:0] idRt,
    input  logic                 idUsesRt,
    input  logic                 idBranch,
    input  logic                 idTaken,
    input  logic                 idJump,
    input  logic                 exRegWrite,
    input  logic                 exMemRead,
    input  logic [REG_ADR_W-1:0] exWriteReg,
    input  logic                 memMemRead,
    input  logic [REG_ADR_W-1:0] memWriteReg,
    input  logic                 dmemBusy,
    output logic [1:0]           pcSrc,
    output logic                 pcWrite,
    output logic                 ifidWrite,
    output logic                 ifFlush,
    output logic                 stall,
    output logic                 pipeHold,
    output logic                 memTimeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]    stallCycles,
    output logic [PERF_W-1:0]    flushCount,
    output logic [PERF_W-1:0]    freezeCycles
`endif
);

    localparam int BUSY_W = $clog2(MEM_TO + 1);

    haz_state_t        r_state;
    haz_state_t        r_resume;
    logic [1:0]        r_stall_cnt;
    logic [BUSY_W-1:0] r_busy_cnt;
    logic              r_mem_timeout;

    haz_state_t        w_next_state;
    haz_state_t        w_next_resume;
    logic [1:0]        w_next_stall_cnt;
    logic [1:0]        w_n;
    pc_src_t           w_pc_src;

    hazard_detect #(
        .REG_ADR_W (REG_ADR_W)
    ) u_hazard_detect (
        .i_id_rs         (idRs),
        .i_id_rt         (idRt),
        .i_id_uses_rt    (idUsesRt),
        .i_id_branch     (idBranch),
        .i_ex_reg_write  (exRegWrite),
        .i_ex_mem_read   (exMemRead),
        .i_ex_write_reg  (exWriteReg),
        .i_mem_mem_read  (memMemRead),
        .i_mem_write_reg (memWriteReg),
        .o_n             (w_n)
    );

    // Next state: memory busy preempts everything, hazards only start from RUN, the
    // remaining bubble count survives a freeze so HAZ resumes exactly where it stopped
    always_comb begin
        w_next_state     = r_state;
        w_next_resume    = r_resume;
        w_next_stall_cnt = r_stall_cnt;
        case (r_state)
            RUN: begin
                if (dmemBusy) begin
                    w_next_state  = FRZ;
                    w_next_resume = RUN;
                end else if (w_n != 2'd0) begin
                    w_next_stall_cnt = w_n - 2'd1;
                    if (w_n != 2'd1) begin
                        w_next_state = HAZ;
                    end
                end
            end
            HAZ: begin
                if (dmemBusy) begin
                    w_next_state  = FRZ;
                    w_next_resume = HAZ;
                end else begin
                    w_next_stall_cnt = r_stall_cnt - 2'd1;
                    if (r_stall_cnt <= 2'd1) begin
                        w_next_state = RUN;
                    end
                end
            end
            FRZ: begin
                if (!dmemBusy) begin
                    w_next_state = r_resume;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // Output decode; a HAZ cycle that sees dmemBusy still shows its bubble but does not
    // consume it, the hold itself comes from FRZ on the following cycles
    always_comb begin
        w_pc_src  = PC_INC;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        ifFlush   = 1'b0;
        stall     = 1'b0;
        pipeHold  = 1'b0;
        if (!rst) begin
            ifFlush = 1'b1;
            stall   = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (dmemBusy) begin
                        pipeHold = 1'b1;
                    end else if (w_n != 2'd0) begin
                        stall = 1'b1;
                    end else if (idJump) begin
                        w_pc_src  = PC_JUMP;
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        ifFlush   = 1'b1;
                    end else if (idBranch && idTaken) begin
                        w_pc_src  = PC_BRANCH;
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        ifFlush   = 1'b1;
                    end else begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                    end
                end
                HAZ: begin
                    stall = 1'b1;
                end
                FRZ: begin
                    pipeHold = 1'b1;
                end
                default: begin
                    pipeHold = 1'b0;
                end
            endcase
        end
    end

    assign pcSrc      = w_pc_src;
    assign memTimeout = r_mem_timeout;

    // State registers and the consecutive-busy watchdog; the timeout flag is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= RUN;
            r_resume      <= RUN;
            r_stall_cnt   <= 2'd0;
            r_busy_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_resume    <= w_next_resume;
            r_stall_cnt <= w_next_stall_cnt;
            if (dmemBusy) begin
                if (r_busy_cnt != BUSY_W'(MEM_TO)) begin
                    r_busy_cnt <= r_busy_cnt + 1'b1;
                end
                if (r_busy_cnt == BUSY_W'(MEM_TO - 1)) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_busy_cnt <= '0;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_count;
    logic [PERF_W-1:0] r_freeze_cycles;

    // Saturating event counters for bubbles, flushes and frozen cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
            r_freeze_cycles <= '0;
        end else begin
            if (stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (ifFlush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
            if (pipeHold && (r_freeze_cycles != '1)) begin
                r_freeze_cycles <= r_freeze_cycles + 1'b1;
            end
        end
    end

    assign stallCycles  = r_stall_cycles;
    assign flushCount   = r_flush_count;
    assign freezeCycles = r_freeze_cycles;
`endif

endmodule
